// File: rtl/gpio_mem_loader_pkg.sv
// gpio_mem_loader_pkg: opcodes, FSM states and GPIO field positions shared by the loader and the micro driver.
package gpio_mem_loader_pkg;
  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_SET_BANK = 3'd1;
  localparam logic [2:0] OP_SET_ADDR = 3'd2;
  localparam logic [2:0] OP_WRITE    = 3'd3;
  localparam logic [2:0] OP_CLEAR    = 3'd4;
  localparam logic [2:0] OP_DONE     = 3'd5;
  localparam int STROBE_BIT = 31;
  localparam int OP_LSB     = 28;
  localparam int ACK_BIT    = 31;
  localparam int BUSY_BIT   = 30;
  localparam int OVR_BIT    = 29;
  localparam int CMD_BIT    = 28;
  localparam int WRAP_BIT   = 27;
  localparam int BANK_LSB   = 16;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR, S_ACK} state_e;
endpackage

// File: rtl/gpio_toggle_sync.sv
// gpio_toggle_sync: 2-flop synchronizer on a toggle strobe with edge detect giving a one-cycle cmd_valid.
module gpio_toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic cmd_valid
);
  logic s1_q, s2_q, prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= strobe;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end
  assign cmd_valid = s2_q ^ prev_q;
endmodule

// File: rtl/gpio_mem_loader.sv
// gpio_mem_loader: GPIO toggle-strobe command loader writing words into the N+2 line memories.
module gpio_mem_loader
  import gpio_mem_loader_pkg::*;
#(
  parameter int GPIO_D     = 32,
  parameter int N          = 2,
  parameter int BITS_DATA  = 13,
  parameter int NB_ADDRESS = 10
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  input  logic [GPIO_D-1:0]     gpio_o_data_tri_o,
  output logic [GPIO_D-1:0]     gpio_i_data_tri_i,
  output logic [N+1:0]          o_we,
  output logic [NB_ADDRESS-1:0] o_WAddr,
  output logic [BITS_DATA-1:0]  o_MemData,
  output logic                  o_load_done,
  output logic                  o_busy
);
  localparam int NBANK = N + 2;
  state_e state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [BITS_DATA-1:0] data_q, data_d;
  logic [3:0] bank_q, bank_d;
  logic [NB_ADDRESS-1:0] addr_q, addr_d;
  logic ack_q, ack_d, ovr_q, ovr_d, cerr_q, cerr_d, wrap_q, wrap_d;
  logic cmd_valid, wr_exec, unused_bits;
  gpio_toggle_sync u_sync (
    .clk      (CLK100MHZ),
    .rst      (rst),
    .strobe   (gpio_o_data_tri_o[STROBE_BIT]),
    .cmd_valid(cmd_valid)
  );
  assign unused_bits = ^gpio_o_data_tri_o[OP_LSB-1:BITS_DATA];
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      data_q  <= '0;
      bank_q  <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
      cerr_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
      cerr_q  <= cerr_d;
      wrap_q  <= wrap_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    ack_d   = ack_q;
    ovr_d   = ovr_q;
    cerr_d  = cerr_q;
    wrap_d  = wrap_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        state_d = S_EXEC;
        op_d    = gpio_o_data_tri_o[OP_LSB +: 3];
        data_d  = gpio_o_data_tri_o[BITS_DATA-1:0];
      end
      S_EXEC: begin
        state_d = (op_q == OP_CLEAR) ? S_CLEAR : S_ACK;
        case (op_q)
          OP_NOP: begin
            ovr_d  = 1'b0;
            cerr_d = 1'b0;
            wrap_d = 1'b0;
          end
          OP_SET_BANK: begin
            if ({1'b0, data_q[3:0]} < 5'(NBANK)) bank_d = data_q[3:0];
            else cerr_d = 1'b1;
          end
          OP_SET_ADDR: addr_d = data_q[NB_ADDRESS-1:0];
          OP_WRITE: begin
            addr_d = addr_q + 1'b1;
            if (&addr_q) wrap_d = 1'b1;
          end
          OP_CLEAR: addr_d = '0;
          OP_DONE: ;
          default: cerr_d = 1'b1;
        endcase
      end
      S_CLEAR: begin
        addr_d = addr_q + 1'b1;
        if (&addr_q) state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
        ack_d   = ~ack_q;
      end
      default: state_d = S_IDLE;
    endcase
    // A strobe edge while a command is in flight is dropped; set after NOP so it is never lost.
    if (cmd_valid && state_q != S_IDLE) ovr_d = 1'b1;
  end
  assign wr_exec     = (state_q == S_EXEC) && (op_q == OP_WRITE);
  assign o_we        = (wr_exec || state_q == S_CLEAR) ? NBANK'(1) << bank_q : '0;
  assign o_WAddr     = addr_q;
  assign o_MemData   = wr_exec ? data_q : '0;
  assign o_load_done = (state_q == S_EXEC) && (op_q == OP_DONE);
  assign o_busy      = state_q != S_IDLE;
  always_comb begin
    gpio_i_data_tri_i                  = '0;
    gpio_i_data_tri_i[ACK_BIT]         = ack_q;
    gpio_i_data_tri_i[BUSY_BIT]        = o_busy;
    gpio_i_data_tri_i[OVR_BIT]         = ovr_q;
    gpio_i_data_tri_i[CMD_BIT]         = cerr_q;
    gpio_i_data_tri_i[WRAP_BIT]        = wrap_q;
    gpio_i_data_tri_i[BANK_LSB +: 4]   = bank_q;
    gpio_i_data_tri_i[NB_ADDRESS-1:0]  = addr_q;
  end
endmodule

// File: tb/tb_gpio_mem_loader.sv
// tb_gpio_mem_loader: directed command sequence with a write scoreboard and immediate-assertion checks.
module tb_gpio_mem_loader;
  logic clk = 1'b0;
  logic rst;
  logic strobe;
  logic [2:0] op_r;
  logic [12:0] dat_r;
  logic [31:0] gpio_o, st;
  logic [3:0] we;
  logic [9:0] waddr;
  logic [12:0] mdata;
  logic load_done, busy;
  logic [26:0] exp_q[$];
  int vec = 0;
  int miss = 0;
  assign gpio_o = {strobe, op_r, 15'b0, dat_r};
  always #5 clk = ~clk;
  gpio_mem_loader dut (
    .CLK100MHZ        (clk),
    .rst              (rst),
    .gpio_o_data_tri_o(gpio_o),
    .gpio_i_data_tri_i(st),
    .o_we             (we),
    .o_WAddr          (waddr),
    .o_MemData        (mdata),
    .o_load_done      (load_done),
    .o_busy           (busy)
  );
  always @(negedge clk) begin
    if (we !== 4'b0) begin
      logic [26:0] e;
      vec++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 27'h7ffffff;
      assert ({we, waddr, mdata} === e)
      else begin
        miss++;
        $error("FAIL write: got we=%b addr=%0h data=%0h expected we=%b addr=%0h data=%0h", we, waddr, mdata, e[26:23], e[22:13], e[12:0]);
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [2:0] op, input logic [12:0] d, output int lat);
    logic old;
    @(negedge clk);
    op_r = op;
    dat_r = d;
    @(negedge clk);
    old = st[31];
    strobe = ~strobe;
    lat = 0;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk);
      if (st[31] !== old) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic cmd(input string tag, input logic [2:0] op, input logic [12:0] d);
    int lat;
    send(op, d, lat);
    chk(tag, lat, 5);
  endtask
  initial begin
    int lat, busy_bad, dn_cnt, dn_at;
    rst = 1'b1;
    strobe = 1'b0;
    op_r = '0;
    dat_r = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_status", st, 32'h0);
    chk("reset_outs", {we, waddr, mdata, load_done, busy}, 0);
    // basic write
    cmd("lat_set_bank1", 3'd1, 13'd1);
    cmd("lat_set_addr5", 3'd2, 13'd5);
    exp_q.push_back({4'b0010, 10'd5, 13'h1AB});
    cmd("lat_write", 3'd3, 13'h1AB);
    chk("status_after_write", st, 32'h8001_0006);
    // wrap
    cmd("lat_set_bank3", 3'd1, 13'd3);
    cmd("lat_set_addr3fe", 3'd2, 13'h3FE);
    exp_q.push_back({4'b1000, 10'h3FE, 13'h001});
    exp_q.push_back({4'b1000, 10'h3FF, 13'h002});
    exp_q.push_back({4'b1000, 10'h000, 13'h003});
    cmd("lat_w1", 3'd3, 13'h001);
    chk("wrap_after_w1", st[27], 0);
    cmd("lat_w2", 3'd3, 13'h002);
    chk("wrap_after_w2", st[27], 1);
    chk("addr_after_w2", st[9:0], 0);
    cmd("lat_w3", 3'd3, 13'h003);
    chk("addr_after_w3", st[9:0], 1);
    chk("wrap_sticky", st[27], 1);
    cmd("lat_nop", 3'd0, 13'd0);
    chk("wrap_cleared", st[29:27], 0);
    // illegal bank and opcode
    cmd("lat_set_bank4", 3'd1, 13'd4);
    chk("bank_kept", st[19:16], 3);
    chk("err_cmd_bank", st[28], 1);
    cmd("lat_nop2", 3'd0, 13'd0);
    chk("err_cmd_cleared", st[28], 0);
    cmd("lat_op7", 3'd7, 13'h1FFF);
    chk("err_cmd_op7", st[28], 1);
    chk("bank_kept_op7", st[19:16], 3);
    chk("addr_kept_op7", st[9:0], 1);
    cmd("lat_nop3", 3'd0, 13'd0);
    // clear bank 0 with a mid-clear strobe toggle
    cmd("lat_set_bank0", 3'd1, 13'd0);
    for (int i = 0; i < 1024; i++) exp_q.push_back({4'b0001, 10'(i), 13'd0});
    @(negedge clk);
    op_r = 3'd4;
    @(negedge clk);
    begin
      logic old;
      old = st[31];
      strobe = ~strobe;
      lat = 0;
      busy_bad = 0;
      for (int i = 1; i <= 1200; i++) begin
        @(negedge clk);
        if (i >= 3 && i <= 1028 && busy !== 1'b1) busy_bad++;
        if (i == 500) strobe = ~strobe;
        if (st[31] !== old) begin
          lat = i;
          break;
        end
      end
      chk("clear_ack_latency", lat, 1029);
      chk("clear_busy", busy_bad, 0);
      chk("clear_overrun", st[29], 1);
      chk("clear_addr0", st[9:0], 0);
      chk("clear_queue_empty", exp_q.size(), 0);
      repeat (10) @(negedge clk);
      chk("no_extra_ack", st[31], !old);
      chk("idle_after_clear", busy, 0);
    end
    cmd("lat_nop4", 3'd0, 13'd0);
    chk("overrun_cleared", st[29], 0);
    // DONE pulse
    @(negedge clk);
    op_r = 3'd5;
    @(negedge clk);
    strobe = ~strobe;
    dn_cnt = 0;
    dn_at = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (load_done === 1'b1) begin
        dn_cnt++;
        dn_at = i;
      end
    end
    chk("done_count", dn_cnt, 1);
    chk("done_cycle", dn_at, 3);
    // reset mid-clear
    for (int i = 0; i < 50; i++) exp_q.push_back({4'b0001, 10'(i), 13'd0});
    @(negedge clk);
    op_r = 3'd4;
    @(negedge clk);
    strobe = ~strobe;
    repeat (53) @(negedge clk);
    rst = 1'b1;
    strobe = 1'b0;
    @(negedge clk);
    chk("rst_mid_status", st, 32'h0);
    chk("rst_mid_outs", {we, waddr, mdata, load_done, busy}, 0);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_writes", exp_q.size(), 0);
    chk("rst_mid_idle", {we, busy}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
